// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter: a rotating priority pointer picks one owner, who keeps
// the grant until done. Optional forced release after MAX_HOLD cycles: `define ARB_TIMEOUT_EN.
module rr_arbiter8 #(
    parameter int N_REQ = 8
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int MAX_HOLD = 16
`endif
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [N_REQ-1:0]         req_i,
    input  logic                     done_i,
    output logic [N_REQ-1:0]         gnt_o,
    output logic [$clog2(N_REQ)-1:0] gnt_idx_o,
    output logic                     gnt_valid_o,
    output logic                     timeout_o
);

    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   gntIdx_q, gntIdx_d;
    logic [IDX_W-1:0]   winnerIdx;
    logic               winnerFound;
    logic               releaseNow;
    logic               holdExpired;

    // Search starts at the pointer and wraps, so the most recent owner has lowest priority.
    always_comb begin
        logic [IDX_W-1:0] candIdx;
        winnerFound = 1'b0;
        winnerIdx   = ptr_q;
        for (int k = 0; k < N_REQ; k++) begin
            candIdx = ptr_q + IDX_W'(k);
            if (!winnerFound && req_i[candIdx]) begin
                winnerFound = 1'b1;
                winnerIdx   = candIdx;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] holdCnt_q, holdCnt_d;
    logic              timeout_q, timeout_d;

    // Counts the grant cycles already shown; the last allowed cycle triggers the release.
    assign holdExpired = (state_q == GRANT) && (holdCnt_q == HOLD_W'(MAX_HOLD - 1));

    always_comb begin
        holdCnt_d = holdCnt_q;
        if (state_q == IDLE) begin
            holdCnt_d = '0;
        end else if (!releaseNow) begin
            holdCnt_d = holdCnt_q + HOLD_W'(1);
        end
    end

    assign timeout_d = holdExpired && !done_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            holdCnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            holdCnt_q <= holdCnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign holdExpired = 1'b0;
    assign timeout_o   = 1'b0;
`endif

    assign releaseNow = (state_q == GRANT) && (done_i || holdExpired);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            gntIdx_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gntIdx_q <= gntIdx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gntIdx_d = gntIdx_q;
        unique case (state_q)
            IDLE: begin
                if (winnerFound) begin
                    state_d  = GRANT;
                    gntIdx_d = winnerIdx;
                end
            end
            GRANT: begin
                if (releaseNow) begin
                    state_d = IDLE;
                    ptr_d   = gntIdx_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant is a decode of the registered index, gated by the registered state.
    always_comb begin
        gnt_o       = '0;
        gnt_valid_o = (state_q == GRANT);
        gnt_idx_o   = gntIdx_q;
        if (state_q == GRANT) begin
            gnt_o[gntIdx_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: vector table, hand-written corner sequences,
// and random traffic against a cycle-level ownership model.
module tb_rr_arbiter8;

`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int MAX_HOLD_TB = 16;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic [7:0] req_i = 8'h00;
    logic       done_i = 1'b0;
    logic [7:0] gnt_o;
    logic [2:0] gnt_idx_o;
    logic       gnt_valid_o;
    logic       timeout_o;

    int vecCount = 0;
    int failCount = 0;

    // Behavioural model state: who owns the resource (-1 = nobody).
    int mOwner, mPtr, mLastIdx, mHeld;
    bit mTimeout;

    typedef struct {
        logic [7:0] req;
        logic       done;
        logic [7:0] expGnt;
        logic [2:0] expIdx;
        logic       expValid;
    } vec_t;

    vec_t vecs[13];

    rr_arbiter8 dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_i      (req_i),
        .done_i     (done_i),
        .gnt_o      (gnt_o),
        .gnt_idx_o  (gnt_idx_o),
        .gnt_valid_o(gnt_valid_o),
        .timeout_o  (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [7:0] g, input logic [2:0] idx,
                               input logic v, input logic to);
        vecCount++;
        if (gnt_o !== g || gnt_idx_o !== idx || gnt_valid_o !== v || timeout_o !== to) begin
            failCount++;
            $display("[TB] FAIL %s: got gnt=%h idx=%0d valid=%b timeout=%b, want gnt=%h idx=%0d valid=%b timeout=%b",
                     name, gnt_o, gnt_idx_o, gnt_valid_o, timeout_o, g, idx, v, to);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] req, input logic done);
        req_i  = req;
        done_i = done;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic modelReset();
        mOwner   = -1;
        mPtr     = 0;
        mLastIdx = 0;
        mHeld    = 0;
        mTimeout = 1'b0;
    endtask

    task automatic modelRelease();
        mPtr   = (mOwner + 1) % 8;
        mOwner = -1;
    endtask

    task automatic modelStep(input logic [7:0] req, input logic done);
        bit found;
        int cand;
        mTimeout = 1'b0;
        if (mOwner < 0) begin
            found = 1'b0;
            for (int k = 0; k < 8; k++) begin
                cand = (mPtr + k) % 8;
                if (!found && req[cand]) begin
                    found    = 1'b1;
                    mOwner   = cand;
                    mLastIdx = cand;
                    mHeld    = 0;
                end
            end
        end else begin
            mHeld++;
            if (done) begin
                modelRelease();
            end else if (TO_EN && mHeld == MAX_HOLD_TB) begin
                modelRelease();
                mTimeout = 1'b1;
            end
        end
    endtask

    task automatic checkModel(input string name);
        logic [7:0] g;
        g = (mOwner >= 0) ? 8'(1 << mOwner) : 8'h00;
        checkOutput(name, g, 3'(mLastIdx), mOwner >= 0, mTimeout);
    endtask

    task automatic doReset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        req_i  = 8'hFF;
        done_i = 1'b0;
        @(posedge clk_i);
        #1;
        checkOutput("reset_state", 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        req_i  = 8'h00;
        modelReset();
    endtask

    initial begin
        vecs[0]  = '{8'h01, 1'b0, 8'h01, 3'd0, 1'b1};
        vecs[1]  = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0};
        vecs[2]  = '{8'h10, 1'b0, 8'h10, 3'd4, 1'b1};
        vecs[3]  = '{8'h11, 1'b1, 8'h00, 3'd4, 1'b0};
        vecs[4]  = '{8'h11, 1'b0, 8'h01, 3'd0, 1'b1};
        vecs[5]  = '{8'h11, 1'b1, 8'h00, 3'd0, 1'b0};
        vecs[6]  = '{8'h11, 1'b0, 8'h10, 3'd4, 1'b1};
        vecs[7]  = '{8'h00, 1'b0, 8'h10, 3'd4, 1'b1};
        vecs[8]  = '{8'h80, 1'b1, 8'h00, 3'd4, 1'b0};
        vecs[9]  = '{8'h80, 1'b0, 8'h80, 3'd7, 1'b1};
        vecs[10] = '{8'hFF, 1'b1, 8'h00, 3'd7, 1'b0};
        vecs[11] = '{8'h00, 1'b1, 8'h00, 3'd7, 1'b0};
        vecs[12] = '{8'hFF, 1'b0, 8'h01, 3'd0, 1'b1};

        doReset();
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].req, vecs[i].done);
            checkOutput($sformatf("table_%0d", i), vecs[i].expGnt, vecs[i].expIdx,
                        vecs[i].expValid, 1'b0);
        end

        // All requesting: owners rotate 0..7 then 0, with an idle cycle after each done.
        doReset();
        for (int k = 0; k < 9; k++) begin
            applyStimulus(8'hFF, 1'b0);
            checkOutput($sformatf("rotate_grant_%0d", k), 8'(1 << (k % 8)), 3'(k % 8), 1'b1, 1'b0);
            applyStimulus(8'hFF, 1'b1);
            checkOutput($sformatf("rotate_idle_%0d", k), 8'h00, 3'(k % 8), 1'b0, 1'b0);
        end

        // Owner that never pulses done.
        doReset();
        applyStimulus(8'h08, 1'b0);
        checkOutput("hold_first", 8'h08, 3'd3, 1'b1, 1'b0);
`ifdef ARB_TIMEOUT_EN
        for (int c = 1; c < 16; c++) begin
            applyStimulus(8'h00, 1'b0);
            checkOutput($sformatf("hold_%0d", c), 8'h08, 3'd3, 1'b1, 1'b0);
        end
        applyStimulus(8'h00, 1'b0);
        checkOutput("timeout_pulse", 8'h00, 3'd3, 1'b0, 1'b1);
        applyStimulus(8'h00, 1'b0);
        checkOutput("timeout_clear", 8'h00, 3'd3, 1'b0, 1'b0);
`else
        for (int c = 1; c <= 100; c++) begin
            applyStimulus(8'h00, 1'b0);
            checkOutput($sformatf("hold_%0d", c), 8'h08, 3'd3, 1'b1, 1'b0);
        end
        applyStimulus(8'h00, 1'b1);
        checkOutput("hold_release", 8'h00, 3'd3, 1'b0, 1'b0);
`endif

        // Asynchronous reset in the middle of a grant, then pointer restarts at 0.
        doReset();
        applyStimulus(8'h40, 1'b0);
        checkOutput("grant_6", 8'h40, 3'd6, 1'b1, 1'b0);
        #2;
        rst_ni = 1'b0;
        #1;
        checkOutput("async_reset", 8'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        applyStimulus(8'hC1, 1'b0);
        checkOutput("post_reset_ptr0", 8'h01, 3'd0, 1'b1, 1'b0);

        // Random traffic against the model.
        doReset();
        for (int n = 0; n < 600; n++) begin
            logic [7:0] r;
            logic       d;
            r = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            d = ($urandom_range(0, 11) == 0);
            applyStimulus(r, d);
            modelStep(r, d);
            checkModel($sformatf("random_%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
        $finish;
    end

endmodule
